vram_line_fetch: RTL
====================

# vram_line_fetch

Burst read engine that fetches a run of consecutive 32-bit words from VRAM through one of the read-only ports of the VRAM arbiter (interfaces 1–3) and buffers them in a small show-ahead FIFO for a downstream renderer (layer or sprite line builder). It converts a single "fetch N words from address A" command into a sequence of strobe/ack transactions and absorbs the arbiter's 1-in-4 slot timing, so the consumer sees a plain valid/pop stream.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2); count width = log2(DEPTH)+1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active low
- start  in  1  command strobe, sampled only in IDLE
- start_addr  in  15  first VRAM word address
- word_count  in  9  words to fetch, 0..511
- abort  in  1  cancel current command, flush FIFO
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse when last word enters FIFO
- vram_addr  out  15  request address to arbiter port
- vram_strobe  out  1  request to arbiter port
- vram_rddata  in  32  arbiter read data, valid in ack cycle
- vram_ack  in  1  arbiter ack, one cycle, one cycle after grant
- rd_data  out  32  FIFO head word (show-ahead)
- rd_valid  out  1  FIFO non-empty
- rd_pop  in  1  consume head word when rd_valid

## Operation
- States: IDLE, FETCH, ABORT.
- IDLE: start=1, word_count≠0 → latch addr/remaining, go FETCH. start=1, word_count=0 → done pulses next cycle, stay IDLE. Start in FETCH/ABORT ignored.
- FETCH: raise vram_strobe when remaining>0, no request outstanding, and fifo_count + 1 ≤ DEPTH (space reserved before request). Once raised, vram_strobe and vram_addr held stable until vram_ack; never withdrawn except by reset.
- vram_ack accepted only while outstanding=1. On accepted ack: push vram_rddata, addr ← addr+1 (15-bit wrap 0x7FFF→0x0000), remaining−1, outstanding←0, vram_strobe drops that edge.
- Ack for last word: done=1 next cycle, go IDLE. FIFO contents are kept for the consumer.
- abort in FETCH: FIFO flushed same edge; if nothing outstanding → IDLE; else → ABORT, strobe held until ack, data discarded, then IDLE. No done pulse. abort in IDLE flushes FIFO only.
- FIFO: push and pop in same cycle allowed at any count; pop with rd_valid=0 ignored; overflow impossible by reservation rule.
- vram_ack while outstanding=0 ignored (covers ack arriving just after reset).

## Timing
- Reset values: busy=0, done=0, vram_strobe=0, vram_addr=0, rd_valid=0, rd_data=0; FIFO empty, outstanding=0, state IDLE.
- start sampled at edge 0 → busy=1 and vram_strobe=1 after edge 0 (cycle 1).
- Arbiter grant occurs in port's slot (1 of every 4 cycles); ack one cycle later; data pushed at the ack edge, rd_valid=1 the following cycle. First-word latency start→rd_valid: 3..6 cycles.
- Peak throughput 1 word / 4 cycles; strobe for next word re-raises cycle after ack, in time for the next slot.
- done asserted exactly one cycle, the cycle after the final accepted ack; busy falls same cycle done rises.
- rst_n=0 mid-operation: state IDLE, strobe dropped, FIFO cleared at next edge; in-flight ack ignored.

## Test plan
- Bench arbiter model (4-slot, ack one cycle after grant, data = addr ^ 0xA5A5_0000): start addr 0x0010, count 8, rd_pop=1 always → words for 0x0010..0x0017 in order, one done pulse, strobe gap ≥1 cycle between requests.
- Wrap: start addr 0x7FFE, count 4, rd_pop=1 → addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- Backpressure: count 10, rd_pop=0 until 4 words buffered → strobe stays low with fifo_count=4; pop 1 → exactly one new request; no overflow, all 10 words delivered in order.
- Abort with outstanding request: count 8, abort in cycle strobe=1 before ack → state ABORT, strobe held until ack, rd_valid=0 afterwards, no done, busy falls cycle after ack.
- word_count=0 → done pulse one cycle after start, vram_strobe never asserted; start while busy → ignored, original command completes unchanged.
- Reset mid-burst: rst_n=0 one cycle while strobe=1 → all outputs at reset values, subsequent stray ack not pushed (rd_valid stays 0).

Source files
------------

// File: rtl/vram_line_fetch.sv
// Burst reader: turns "fetch N words from A" into arbiter strobe/ack transactions feeding a show-ahead FIFO.
// Latency: strobe one cycle after start, data visible on rd_valid the cycle after its ack (3..6 cycles first word).
// Backpressure: a request is only raised when a FIFO slot is free, so a stalled consumer parks the strobe low.
module vram_line_fetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [14:0] start_addr,
    input  logic [8:0]  word_count,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [14:0] vram_addr,
    output logic        vram_strobe,
    input  logic [31:0] vram_rddata,
    input  logic        vram_ack,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_pop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ABORT} state_t;

    state_t        state_q, state_d;
    logic [14:0]   addr_q, addr_d;
    logic [8:0]    remaining_q, remaining_d;
    logic          outstanding_q, outstanding_d;
    logic          done_q, done_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;

    logic ack_acc;
    logic pop;
    logic push;
    logic flush;
    logic space;

    assign ack_acc     = vram_ack & outstanding_q;
    assign pop         = rd_pop & (count_q != '0);
    // A slot is reserved before requesting; only one request is ever in flight.
    assign space       = (count_q != FULL);

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign vram_addr   = addr_q;
    assign vram_strobe = outstanding_q;
    assign rd_valid    = (count_q != '0);
    assign rd_data     = (count_q != '0) ? mem_q[rptr_q] : '0;

    // Command sequencing: next state, request issue/retire, done pulse.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        done_d        = 1'b0;
        push          = 1'b0;
        flush         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (abort) begin
                    flush = 1'b1;
                end else if (start) begin
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d        = start_addr;
                        remaining_d   = word_count;
                        state_d       = S_FETCH;
                        outstanding_d = space;
                    end
                end
            end
            S_FETCH: begin
                if (abort) begin
                    flush = 1'b1;
                    // An in-flight request must still be retired by its ack.
                    if (outstanding_q && !ack_acc) begin
                        state_d = S_ABORT;
                    end else begin
                        outstanding_d = 1'b0;
                        state_d       = S_IDLE;
                    end
                end else if (ack_acc) begin
                    push          = 1'b1;
                    addr_d        = addr_q + 15'd1;
                    remaining_d   = remaining_q - 9'd1;
                    outstanding_d = 1'b0;
                    if (remaining_q == 9'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (!outstanding_q && remaining_q != '0 && space) begin
                    outstanding_d = 1'b1;
                end
            end
            S_ABORT: begin
                flush = abort;
                if (ack_acc) begin
                    outstanding_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d       = S_IDLE;
                outstanding_d = 1'b0;
            end
        endcase
    end

    // FIFO pointer/occupancy and storage update; flush overrides push and pop.
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = vram_rddata;
                wptr_d        = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= 1'b0;
            done_q        <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            done_q        <= done_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end
endmodule
